ib_rt_fifo: RTL and testbench

- Per-port input buffer that sits directly upstream of the route decoder, dec_rt.
- Stores incoming 66-bit flits in a FIFO and presents the head flit already split into um_type, addr0 and addr1 so dec_rt can route it.
- Supports partial multicast service: after a forward-and-absorb decision, the head's destination bitmap is rewritten with dec_rt's addr1_rm, and the flit stays queued until it is fully served.
- Returns one credit to the upstream router per dequeued flit.

---
 rtl/ib_rt_fifo.sv | 84 ++++++++
 tb/tb_ib_rt_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ib_rt_fifo.sv
// Per-port input buffer feeding dec_rt: a small flit FIFO whose head is presented
// pre-split into um_type/addr0/addr1, with in-place rewrite of the multicast bitmap.
module ib_rt_fifo #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [65:0]      in_data,
    input  logic             out_ready,
    input  logic             hd_upd,
    input  logic [55:0]      hd_addr1,
    output logic             out_valid,
    output logic [65:0]      out_data,
    output logic             um_type,
    output logic [10:0]      addr0,
    output logic [55:0]      addr1,
    output logic             credit_out,
    output logic [PTRW:0]    count,
    output logic             ovf
);

    localparam logic [PTRW:0] FULL = (PTRW + 1)'(DEPTH);

    logic [65:0]     mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [65:0]     head;
    logic            full;
    logic            pop;
    logic            push;
    logic            upd;

    assign head      = mem[rd_ptr];
    assign full      = (count == FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    // A rewrite only makes sense for a multicast head that is staying in the queue.
    assign upd       = hd_upd && out_valid && !out_ready && head[63];

    assign out_data  = out_valid ? head : '0;
    assign um_type   = out_data[63];
    assign addr0     = um_type ? '0 : out_data[62:52];
    assign addr1     = um_type ? out_data[62:7] : '0;

    // Storage needs no reset; the write slot differs from the head slot whenever both are active.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        if (upd) begin
            mem[rd_ptr][62:7] <= hd_addr1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            credit_out <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ib_rt_fifo.sv
// Self-checking bench for ib_rt_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ib_rt_fifo;

    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [65:0]     in_data = '0;
    logic            out_ready = 1'b0;
    logic            hd_upd = 1'b0;
    logic [55:0]     hd_addr1 = '0;
    logic            out_valid;
    logic [65:0]     out_data;
    logic            um_type;
    logic [10:0]     addr0;
    logic [55:0]     addr1;
    logic            credit_out;
    logic [PTRW:0]   count;
    logic            ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [65:0] m_q[$];
    logic        m_credit;
    logic        m_ovf;

    ib_rt_fifo #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .hd_upd(hd_upd), .hd_addr1(hd_addr1),
        .out_valid(out_valid), .out_data(out_data), .um_type(um_type),
        .addr0(addr0), .addr1(addr1), .credit_out(credit_out),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue whose front is the head flit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_credit = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            automatic bit is_full = (m_q.size() == DEPTH);
            automatic bit do_pop  = (m_q.size() != 0) && out_ready;
            automatic bit do_push = in_valid && (!is_full || do_pop);
            if (in_valid && is_full && !do_pop) m_ovf = 1'b1;
            if (hd_upd && m_q.size() != 0 && !out_ready && m_q[0][63])
                m_q[0][62:7] = hd_addr1;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(in_data);
            m_credit = do_pop;
        end
    end

    always @(negedge clk) begin
        automatic logic [65:0] e_data = (m_q.size() != 0) ? m_q[0] : 66'd0;
        automatic logic        e_um   = e_data[63];
        checkOutput("out_valid", 66'(out_valid), 66'(m_q.size() != 0));
        checkOutput("out_data", out_data, e_data);
        checkOutput("um_type", 66'(um_type), 66'(e_um));
        checkOutput("addr0", 66'(addr0), e_um ? 66'd0 : 66'(e_data[62:52]));
        checkOutput("addr1", 66'(addr1), e_um ? 66'(e_data[62:7]) : 66'd0);
        checkOutput("count", 66'(count), 66'(m_q.size()));
        checkOutput("credit_out", 66'(credit_out), 66'(m_credit));
        checkOutput("ovf", 66'(ovf), 66'(m_ovf));
    end

    // Hold the given inputs across one rising edge; returns 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [65:0] d, input logic r,
                                 input logic u, input logic [55:0] a);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        hd_upd    = u;
        hd_addr1  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 66'd0, 1'b0, 1'b0, 56'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    function automatic logic [65:0] uni(input logic [10:0] dst, input logic [51:0] tail);
        return {2'b00, 1'b0, dst, tail};
    endfunction

    function automatic logic [65:0] mc(input logic [1:0] ft, input logic [55:0] bm, input logic [6:0] tail);
        return {ft, 1'b1, bm, tail};
    endfunction

    initial begin
        logic [65:0] f [8];
        logic [95:0] r;
        logic [65:0] nf;

        idle();
        rst = 1'b0;
        checkOutput("reset count", 66'(count), 66'd0);
        checkOutput("reset out_valid", 66'(out_valid), 66'd0);

        // Unicast split and single credit pulse
        applyStimulus(1'b1, uni(11'd12, 52'd0), 1'b0, 1'b0, 56'd0);
        checkOutput("uni valid", 66'(out_valid), 66'd1);
        checkOutput("uni um_type", 66'(um_type), 66'd0);
        checkOutput("uni addr0", 66'(addr0), 66'd12);
        checkOutput("uni addr1", 66'(addr1), 66'd0);
        applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);
        checkOutput("uni credit", 66'(credit_out), 66'd1);
        checkOutput("uni count", 66'(count), 66'd0);
        idle();
        checkOutput("uni credit drop", 66'(credit_out), 66'd0);

        // Multicast partial service
        applyStimulus(1'b1, mc(2'b01, 56'h111, 7'h5A), 1'b0, 1'b0, 56'd0);
        applyStimulus(1'b0, 66'd0, 1'b0, 1'b1, 56'h110);
        checkOutput("mc addr1", 66'(addr1), 66'h110);
        checkOutput("mc count", 66'(count), 66'd1);
        checkOutput("mc hdr", 66'(out_data[65:63]), 66'b011);
        checkOutput("mc tail", 66'(out_data[6:0]), 66'h5A);
        applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);
        checkOutput("mc credit", 66'(credit_out), 66'd1);

        // Fill, overflow, drain, refill across wrap
        for (int i = 0; i < 8; i++) f[i] = uni(11'(i + 100), 52'(i * 7 + 1));
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, f[i], 1'b0, 1'b0, 56'd0);
        checkOutput("fill count", 66'(count), 66'd4);
        applyStimulus(1'b1, uni(11'd999, 52'd5), 1'b0, 1'b0, 56'd0);
        checkOutput("ovf set", 66'(ovf), 66'd1);
        checkOutput("ovf count", 66'(count), 66'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain order", out_data, f[i]);
            applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);
        end
        for (int i = 4; i < 8; i++) applyStimulus(1'b1, f[i], 1'b0, 1'b0, 56'd0);

        // Full with push and pop together
        nf = uni(11'd77, 52'hABC);
        applyStimulus(1'b1, nf, 1'b1, 1'b0, 56'd0);
        checkOutput("fullpp count", 66'(count), 66'd4);
        checkOutput("fullpp credit", 66'(credit_out), 66'd1);
        checkOutput("fullpp ovf", 66'(ovf), 66'd1);
        for (int i = 5; i < 8; i++) begin
            checkOutput("wrap order", out_data, f[i]);
            applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);
        end
        checkOutput("fullpp last", out_data, nf);
        applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);

        // Rewrite conflicting with pop
        doReset();
        checkOutput("ovf cleared", 66'(ovf), 66'd0);
        applyStimulus(1'b1, mc(2'b10, 56'hF0F, 7'h11), 1'b0, 1'b0, 56'd0);
        applyStimulus(1'b1, mc(2'b11, 56'h0A0, 7'h22), 1'b0, 1'b0, 56'd0);
        checkOutput("conf head", out_data, mc(2'b10, 56'hF0F, 7'h11));
        applyStimulus(1'b0, 66'd0, 1'b1, 1'b1, 56'h001);
        checkOutput("conf credit", 66'(credit_out), 66'd1);
        checkOutput("conf second", out_data, mc(2'b11, 56'h0A0, 7'h22));
        applyStimulus(1'b0, 66'd0, 1'b1, 1'b0, 56'd0);

        // Reset mid-stream with three flits queued
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, f[i], 1'b0, 1'b0, 56'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst count", 66'(count), 66'd0);
        checkOutput("rst valid", 66'(out_valid), 66'd0);
        checkOutput("rst addr0", 66'(addr0), 66'd0);
        checkOutput("rst addr1", 66'(addr1), 66'd0);
        idle();
        checkOutput("rst credit", 66'(credit_out), 66'd0);
        rst = 1'b0;
        idle();
        checkOutput("rst credit after", 66'(credit_out), 66'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                r = {$urandom(), $urandom(), $urandom()};
                applyStimulus($urandom_range(0, 9) < 6, r[65:0], $urandom_range(0, 1) == 1,
                              $urandom_range(0, 9) < 3, 56'({$urandom(), $urandom()}));
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
